// File: rtl/volume_ctrl.sv
// Debounced up/down volume control with saturating counter and step pulses.
// Define VOLUME_CTRL_REPEAT_EN to compile in hold-to-repeat stepping.
module volume_ctrl #(
  parameter int WIDTH        = 4,
  parameter int DEBOUNCE     = 4,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 4,
  parameter int VOL_INIT     = 8
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] volume,
  output logic             increment,
  output logic             decrement,
  output logic             at_max,
  output logic             at_min
);

  localparam int DBW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
  localparam logic [WIDTH-1:0] VOL_MAX = '1;

  if (DEBOUNCE < 1 || REPEAT_DELAY < 2 || REPEAT_RATE < 1 ||
      VOL_INIT < 0 || VOL_INIT >= (1 << WIDTH)) begin : g_bad_params
    $error("volume_ctrl: illegal parameter combination");
  end

`ifdef VOLUME_CTRL_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RCW  = $clog2(RMAX);

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    UP_HOLD     = 3'd1,
    DOWN_HOLD   = 3'd2,
    UP_REPEAT   = 3'd3,
    DOWN_REPEAT = 3'd4
  } state_t;

  logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
`else
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    UP_HOLD   = 2'd1,
    DOWN_HOLD = 2'd2
  } state_t;
`endif

  state_t state_q, state_d;

  // Index 0 is the up button, index 1 the down button.
  logic [1:0]     sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
  logic [DBW-1:0] db_cnt_q [2];
  logic [DBW-1:0] db_cnt_d [2];

  logic [WIDTH-1:0] vol_q, vol_d;
  logic             inc_q, inc_d, dec_q, dec_d;
  logic             step_up, step_dn;
  logic             filt_up, filt_dn;

  assign filt_up = filt_q[0];
  assign filt_dn = filt_q[1];

  // The filtered level follows the synchronised one only after it has
  // disagreed for DEBOUNCE cycles in a row; any agreement restarts the count.
  always_comb begin
    sync1_d = {down, up};
    sync2_d = sync1_q;
    for (int i = 0; i < 2; i++) begin
      filt_d[i]   = filt_q[i];
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == filt_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DBW'(DEBOUNCE - 1)) begin
        filt_d[i]   = sync2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    step_up = 1'b0;
    step_dn = 1'b0;
`ifdef VOLUME_CTRL_REPEAT_EN
    rep_cnt_d = rep_cnt_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef VOLUME_CTRL_REPEAT_EN
        rep_cnt_d = '0;
`endif
        if (filt_up && !filt_dn) begin
          step_up = 1'b1;
          state_d = UP_HOLD;
        end else if (filt_dn && !filt_up) begin
          step_dn = 1'b1;
          state_d = DOWN_HOLD;
        end
      end
      UP_HOLD: begin
        if (!filt_up) begin
          state_d = IDLE;
`ifdef VOLUME_CTRL_REPEAT_EN
        end else if (rep_cnt_q == RCW'(REPEAT_DELAY - 1)) begin
          step_up   = 1'b1;
          state_d   = UP_REPEAT;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RCW'(1);
`endif
        end
      end
      DOWN_HOLD: begin
        if (!filt_dn) begin
          state_d = IDLE;
`ifdef VOLUME_CTRL_REPEAT_EN
        end else if (rep_cnt_q == RCW'(REPEAT_DELAY - 1)) begin
          step_dn   = 1'b1;
          state_d   = DOWN_REPEAT;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RCW'(1);
`endif
        end
      end
`ifdef VOLUME_CTRL_REPEAT_EN
      UP_REPEAT: begin
        if (!filt_up) begin
          state_d = IDLE;
        end else if (rep_cnt_q == RCW'(REPEAT_RATE - 1)) begin
          step_up   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RCW'(1);
        end
      end
      DOWN_REPEAT: begin
        if (!filt_dn) begin
          state_d = IDLE;
        end else if (rep_cnt_q == RCW'(REPEAT_RATE - 1)) begin
          step_dn   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RCW'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // A step into a limit is swallowed: no pulse, volume held, FSM unaffected.
  always_comb begin
    vol_d = vol_q;
    inc_d = 1'b0;
    dec_d = 1'b0;
    if (step_up && vol_q != VOL_MAX) begin
      vol_d = vol_q + WIDTH'(1);
      inc_d = 1'b1;
    end else if (step_dn && vol_q != '0) begin
      vol_d = vol_q - WIDTH'(1);
      dec_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= IDLE;
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      vol_q       <= WIDTH'(VOL_INIT);
      inc_q       <= 1'b0;
      dec_q       <= 1'b0;
`ifdef VOLUME_CTRL_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      vol_q       <= vol_d;
      inc_q       <= inc_d;
      dec_q       <= dec_d;
`ifdef VOLUME_CTRL_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign volume    = vol_q;
  assign increment = inc_q;
  assign decrement = dec_q;
  assign at_max    = (vol_q == VOL_MAX);
  assign at_min    = (vol_q == '0);

endmodule

// File: tb/tb_volume_ctrl.sv
// Directed self-checking bench for volume_ctrl at default parameters.
// Expectations follow VOLUME_CTRL_REPEAT_EN when that macro is defined.
module tb_volume_ctrl;

  logic       clk = 1'b0;
  logic       n_reset;
  logic       up;
  logic       down;
  logic [3:0] volume;
  logic       increment;
  logic       decrement;
  logic       at_max;
  logic       at_min;

  int compared   = 0;
  int mismatched = 0;

  int cyc = 0;
  int inc_times [$];
  int dec_times [$];
  int overlap = 0;
  int base_inc, base_dec;
  int s, r, vol_model;

  volume_ctrl dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .up        (up),
    .down      (down),
    .volume    (volume),
    .increment (increment),
    .decrement (decrement),
    .at_max    (at_max),
    .at_min    (at_min)
  );

  always #5 clk = ~clk;

  // cyc is the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  // Log every pulse against the edge that produced it.
  always @(negedge clk) begin
    if (increment) inc_times.push_back(cyc);
    if (decrement) dec_times.push_back(cyc);
    if (increment && decrement) overlap++;
  end

  // Act just after the falling edge, after the pulse logger has run.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic u, input logic d, input int cycles);
    up   = u;
    down = d;
    repeat (cycles) tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic mark();
    base_inc = inc_times.size();
    base_dec = dec_times.size();
  endtask

  function automatic int incCount();
    return inc_times.size() - base_inc;
  endfunction

  function automatic int decCount();
    return dec_times.size() - base_dec;
  endfunction

  function automatic int incAt(input int k);
    return (inc_times.size() > base_inc + k) ? inc_times[base_inc + k] : -1;
  endfunction

  initial begin
    n_reset = 1'b0;
    up      = 1'b0;
    down    = 1'b0;
    repeat (3) tick();
    checkOutput("reset_volume", 32'(volume), 32'd8);
    checkOutput("reset_inc", 32'(increment), 32'd0);
    checkOutput("reset_dec", 32'(decrement), 32'd0);
    checkOutput("reset_at_max", 32'(at_max), 32'd0);
    checkOutput("reset_at_min", 32'(at_min), 32'd0);
    n_reset = 1'b1;
    repeat (3) tick();

    // Single press: one pulse 7 edges after the first sample of up.
    mark();
    s = cyc;
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("press_inc_count", 32'(incCount()), 32'd1);
    checkOutput("press_latency", 32'(incAt(0)), 32'(s + 7));
    checkOutput("press_volume", 32'(volume), 32'd9);
    checkOutput("press_dec_count", 32'(decCount()), 32'd0);

    // Glitches shorter than the debounce window are ignored.
    mark();
    repeat (5) begin
      applyStimulus(1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 5);
    end
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("glitch_inc_count", 32'(incCount()), 32'd0);
    checkOutput("glitch_volume", 32'(volume), 32'd9);

    // Long hold; raw release timed so filtered up drops 30 edges after the first pulse.
    mark();
    s = cyc;
    applyStimulus(1'b1, 1'b0, 31);
    applyStimulus(1'b0, 1'b0, 20);
    checkOutput("hold_first", 32'(incAt(0)), 32'(s + 7));
`ifdef VOLUME_CTRL_REPEAT_EN
    checkOutput("hold_inc_count", 32'(incCount()), 32'd5);
    checkOutput("hold_second", 32'(incAt(1)), 32'(s + 23));
    checkOutput("hold_last", 32'(incAt(4)), 32'(s + 35));
    checkOutput("hold_volume", 32'(volume), 32'd14);
    vol_model = 14;
`else
    checkOutput("hold_inc_count", 32'(incCount()), 32'd1);
    checkOutput("hold_volume", 32'(volume), 32'd10);
    vol_model = 10;
`endif

    // Climb to full scale, then try to go past it.
    while (vol_model < 15) begin
      applyStimulus(1'b1, 1'b0, 10);
      applyStimulus(1'b0, 1'b0, 12);
      vol_model++;
    end
    checkOutput("top_volume", 32'(volume), 32'd15);
    checkOutput("top_at_max", 32'(at_max), 32'd1);
    checkOutput("top_at_min", 32'(at_min), 32'd0);
    mark();
    applyStimulus(1'b1, 1'b0, 10);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("sat_inc_count", 32'(incCount()), 32'd0);
    checkOutput("sat_volume", 32'(volume), 32'd15);
    checkOutput("sat_at_max", 32'(at_max), 32'd1);
    mark();
    applyStimulus(1'b0, 1'b1, 10);
    applyStimulus(1'b0, 1'b0, 12);
    checkOutput("down_dec_count", 32'(decCount()), 32'd1);
    checkOutput("down_volume", 32'(volume), 32'd14);
    checkOutput("down_at_max", 32'(at_max), 32'd0);

    // Both buttons together stay idle; dropping down lets up through.
    mark();
    applyStimulus(1'b1, 1'b1, 15);
    checkOutput("both_inc_count", 32'(incCount()), 32'd0);
    checkOutput("both_dec_count", 32'(decCount()), 32'd0);
    checkOutput("both_volume", 32'(volume), 32'd14);
    mark();
    s = cyc;
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("release_inc_count", 32'(incCount()), 32'd1);
    checkOutput("release_latency", 32'(incAt(0)), 32'(s + 7));
    checkOutput("release_volume", 32'(volume), 32'd15);
    checkOutput("release_dec_count", 32'(decCount()), 32'd0);

    // Reset in the middle of a hold, with up kept pressed throughout.
    n_reset = 1'b0;
    repeat (2) tick();
    n_reset = 1'b1;
    repeat (2) tick();
    mark();
    s = cyc;
    applyStimulus(1'b1, 1'b0, 32);
`ifdef VOLUME_CTRL_REPEAT_EN
    checkOutput("midhold_volume", 32'(volume), 32'd12);
    checkOutput("midhold_inc_count", 32'(incCount()), 32'd4);
`else
    checkOutput("midhold_volume", 32'(volume), 32'd9);
    checkOutput("midhold_inc_count", 32'(incCount()), 32'd1);
`endif
    n_reset = 1'b0;
    #1;
    checkOutput("async_reset_volume", 32'(volume), 32'd8);
    checkOutput("async_reset_inc", 32'(increment), 32'd0);
    checkOutput("async_reset_dec", 32'(decrement), 32'd0);
    repeat (3) tick();
    mark();
    n_reset = 1'b1;
    r = cyc;
    applyStimulus(1'b1, 1'b0, 12);
    applyStimulus(1'b0, 1'b0, 15);
    checkOutput("post_reset_inc_count", 32'(incCount()), 32'd1);
    checkOutput("post_reset_latency", 32'(incAt(0)), 32'(r + 7));
    checkOutput("post_reset_volume", 32'(volume), 32'd9);

    checkOutput("pulse_overlap", 32'(overlap), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
